// File: rtl/dla64_pkg.sv
// dla64_pkg: state encoding, phase codes and default word-count width for the DLA64 load controller
package dla64_pkg;
  localparam int CNT_W_DEF = 16;
  localparam logic [1:0] PH_IDLE = 2'd0, PH_BIAS = 2'd1, PH_KER = 2'd2, PH_IF = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE, S_BIAS_RUN, S_BIAS_WAIT, S_KER_RUN, S_KER_WAIT, S_IF_RUN, S_IF_WAIT, S_DONE
  } ld_state_t;
  // nz = {if, ker, bias} count nonzero; picks the next phase after `from` that has words
  function automatic ld_state_t next_run(input ld_state_t from, input logic [2:0] nz);
    logic [2:0] m;
    m = from == S_IDLE ? nz : from == S_BIAS_WAIT ? nz & 3'b110 : from == S_KER_WAIT ? nz & 3'b100 : 3'b000;
    return m[0] ? S_BIAS_RUN : m[1] ? S_KER_RUN : m[2] ? S_IF_RUN : S_DONE;
  endfunction
  function automatic logic [1:0] phase_of(input ld_state_t s);
    return s inside {S_BIAS_RUN, S_BIAS_WAIT} ? PH_BIAS :
           s inside {S_KER_RUN, S_KER_WAIT} ? PH_KER :
           s inside {S_IF_RUN, S_IF_WAIT} ? PH_IF : PH_IDLE;
  endfunction
endpackage

// File: rtl/ld_word_cnt.sv
// ld_word_cnt: loadable down-counter with decrement enable and count==1 / count==0 flags
module ld_word_cnt #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         one,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
  assign one  = count == W'(1);
  assign zero = count == '0;
endmodule

// File: rtl/load_phase_ctrl.sv
// load_phase_ctrl: streams get_ins words to the bias, kernel and ifmap store engines in turn.
// Define LDCTRL_STALL_CNT_EN to add the stall_cycles output.
module load_phase_ctrl import dla64_pkg::*; #(parameter int CNT_W = CNT_W_DEF) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load_start,
  input  logic [CNT_W-1:0] bias_words,
  input  logic [CNT_W-1:0] ker_words,
  input  logic [CNT_W-1:0] if_words,
  input  logic             ds_empty_n,
  output logic             ds_read,
  output logic             bias_start,
  output logic             ker_start,
  output logic             if_start,
  output logic             bias_empty_n,
  output logic             ker_empty_n,
  output logic             if_empty_n,
  input  logic             bias_read,
  input  logic             ker_read,
  input  logic             if_read,
  input  logic             bias_done,
  input  logic             ker_done,
  input  logic             if_done,
  output logic             busy,
  output logic [1:0]       phase,
`ifdef LDCTRL_STALL_CNT_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic             load_done
);
  ld_state_t state, nxt;
  logic [CNT_W-1:0] bias_l, ker_l, if_l, src_b, src_k, src_i, lv;
  logic [2:0] nz;
  logic flag, act_read, act_done, cnt_one, cnt_zero, enter_run;
  // in IDLE the live inputs are used so the first phase can load its count on the start edge
  assign src_b = state == S_IDLE ? bias_words : bias_l;
  assign src_k = state == S_IDLE ? ker_words : ker_l;
  assign src_i = state == S_IDLE ? if_words : if_l;
  assign nz = {src_i != '0, src_k != '0, src_b != '0};
  assign act_read = (state == S_BIAS_RUN & bias_read) | (state == S_KER_RUN & ker_read) | (state == S_IF_RUN & if_read);
  assign act_done = (phase_of(state) == PH_BIAS & bias_done) | (phase_of(state) == PH_KER & ker_done) |
                    (phase_of(state) == PH_IF & if_done);
  assign ds_read = act_read & ds_empty_n & !cnt_zero;
  assign bias_empty_n = state == S_BIAS_RUN & ds_empty_n;
  assign ker_empty_n = state == S_KER_RUN & ds_empty_n;
  assign if_empty_n = state == S_IF_RUN & ds_empty_n;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (load_start) nxt = next_run(S_IDLE, nz);
      S_BIAS_RUN, S_KER_RUN, S_IF_RUN:
        if (ds_read && cnt_one) nxt = state == S_BIAS_RUN ? S_BIAS_WAIT : state == S_KER_RUN ? S_KER_WAIT : S_IF_WAIT;
      S_BIAS_WAIT, S_KER_WAIT, S_IF_WAIT: if (flag) nxt = next_run(state, nz);
      default: nxt = S_IDLE;
    endcase
  end
  assign enter_run = nxt != state && nxt inside {S_BIAS_RUN, S_KER_RUN, S_IF_RUN};
  assign lv = nxt == S_BIAS_RUN ? src_b : nxt == S_KER_RUN ? src_k : src_i;
  ld_word_cnt #(.W(CNT_W)) u_cnt (
    .clk(aclk), .rst_n(aresetn), .load(enter_run), .load_val(lv), .dec(ds_read), .one(cnt_one), .zero(cnt_zero)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= S_IDLE;
      bias_l <= '0;
      ker_l <= '0;
      if_l <= '0;
      flag <= 1'b0;
      busy <= 1'b0;
      phase <= PH_IDLE;
      bias_start <= 1'b0;
      ker_start <= 1'b0;
      if_start <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && load_start) {bias_l, ker_l, if_l} <= {bias_words, ker_words, if_words};
      flag <= enter_run ? 1'b0 : flag | act_done;
      busy <= nxt != S_IDLE;
      phase <= phase_of(nxt);
      bias_start <= enter_run && nxt == S_BIAS_RUN;
      ker_start <= enter_run && nxt == S_KER_RUN;
      if_start <= enter_run && nxt == S_IF_RUN;
      load_done <= nxt == S_DONE;
    end
`ifdef LDCTRL_STALL_CNT_EN
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) stall_cycles <= '0;
    else if (state == S_IDLE && load_start) stall_cycles <= '0;
    else if (act_read && !ds_empty_n && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_load_phase_ctrl.sv
// tb_load_phase_ctrl: randomized engine/stream stimulus checked against a per-load word and timing model
module tb_load_phase_ctrl;
  logic aclk = 0, aresetn = 0, load_start = 0, ds_empty_n = 0;
  logic [15:0] bias_words = 0, ker_words = 0, if_words = 0;
  logic bias_read = 0, ker_read = 0, if_read = 0, bias_done = 0, ker_done = 0, if_done = 0;
  logic ds_read, bias_start, ker_start, if_start, bias_empty_n, ker_empty_n, if_empty_n, busy, load_done;
  logic [1:0] phase;
`ifdef LDCTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  load_phase_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .load_start(load_start),
    .bias_words(bias_words), .ker_words(ker_words), .if_words(if_words),
    .ds_empty_n(ds_empty_n), .ds_read(ds_read),
    .bias_start(bias_start), .ker_start(ker_start), .if_start(if_start),
    .bias_empty_n(bias_empty_n), .ker_empty_n(ker_empty_n), .if_empty_n(if_empty_n),
    .bias_read(bias_read), .ker_read(ker_read), .if_read(if_read),
    .bias_done(bias_done), .ker_done(ker_done), .if_done(if_done),
    .busy(busy), .phase(phase),
`ifdef LDCTRL_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .load_done(load_done)
  );
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  int tgt[3], rcv[3], dc[3], st_cnt[3];
  bit cur[3], fin[3];
  logic rd[3], dn[3];
  int ph_idx, ds_cnt, viol, ld_cnt, stall_exp, ev_t, ev_g, dmax_m;
  bit in_load = 0, cont_m, bub_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // engines: read continuously or randomly, pulse done once after (or with) their last word
  task automatic drive(input bit ls, input int b, input int k, input int i);
    ds_empty_n = bub_m ? ($urandom_range(0, 9) < 7) : 1'b1;
    for (int e = 0; e < 3; e++) begin
      rd[e] = cont_m ? 1'b1 : ($urandom_range(0, 3) != 0);
      dn[e] = 1'b0;
      if (cur[e]) begin
        if (rcv[e] == tgt[e]) begin
          if (dc[e] == 0) dn[e] = 1'b1;
          else dc[e]--;
        end else if (rcv[e] == tgt[e] - 1 && rd[e] && ds_empty_n && dc[e] == 0) dn[e] = 1'b1;
      end else if (fin[e] || tgt[e] == 0) dn[e] = ($urandom_range(0, 7) == 0);
    end
    {bias_read, ker_read, if_read} = {rd[0], rd[1], rd[2]};
    {bias_done, ker_done, if_done} = {dn[0], dn[1], dn[2]};
    load_start = ls | (in_load && $urandom_range(0, 19) == 0);
    if (ls) {bias_words, ker_words, if_words} = {b[15:0], k[15:0], i[15:0]};
    else {bias_words, ker_words, if_words} = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  task automatic sample();
    logic [2:0] st, em, rv;
    int nh;
    st = {if_start, ker_start, bias_start};
    em = {if_empty_n, ker_empty_n, bias_empty_n};
    rv = {if_read, ker_read, bias_read};
    for (int e = 0; e < 3; e++)
      if (st[e]) begin
        st_cnt[e]++;
        chk("start_gap", 64'(cyc - ev_t), 64'(ev_g));
        chk("start_phase", 64'(phase), 64'(e + 1));
        if (e <= ph_idx) viol++;
        ph_idx = e;
        cur[e] = 1;
        dc[e] = $urandom_range(0, dmax_m);
      end
    nh = 0;
    for (int e = 0; e < 3; e++) begin
      if (em[e] && (e != ph_idx || !ds_empty_n)) viol++;
      if (em[e] && rv[e]) begin
        nh++;
        rcv[e]++;
      end
    end
    if (ds_read && !ds_empty_n) viol++;
    if (nh != int'(ds_read)) viol++;
    ds_cnt += int'(ds_read);
    if (ph_idx >= 0 && rcv[ph_idx] < tgt[ph_idx] && rv[ph_idx] && !ds_empty_n) stall_exp++;
    for (int e = 0; e < 3; e++)
      if (dn[e] && cur[e]) begin
        cur[e] = 0;
        fin[e] = 1;
        ev_t = cyc;
        ev_g = 2;
      end
    if (load_done) begin
      ld_cnt++;
      chk("done_gap", 64'(cyc - ev_t), 64'(ev_g));
      in_load = 0;
    end
  endtask

  task automatic run_load(input int b, input int k, input int i, input bit cont, input bit bub,
                          input int dmax, input bit abort);
    tgt = '{b, k, i};
    for (int e = 0; e < 3; e++) begin
      rcv[e] = 0; cur[e] = 0; fin[e] = 0; st_cnt[e] = 0; dc[e] = 0;
    end
    ph_idx = -1; ds_cnt = 0; viol = 0; ld_cnt = 0; stall_exp = 0;
    cont_m = cont; bub_m = bub; dmax_m = dmax;
    @(posedge aclk); #1;
    drive(1, b, k, i);
    ev_t = cyc; ev_g = 1; in_load = 1;
    @(negedge aclk); sample();
    for (int n = 0; n < 2000 && in_load; n++) begin
      if (abort && rcv[1] >= 2) break;
      @(posedge aclk); #1;
      drive(0, 0, 0, 0);
      @(negedge aclk); sample();
      if (n == 0) chk("busy_rise", 64'(busy), 1);
    end
    if (abort) begin
      #2 aresetn = 0;
      #1 chk("rst_async", 64'({ds_read, bias_start, ker_start, if_start, bias_empty_n, ker_empty_n,
                               if_empty_n, busy, phase, load_done}), 0);
`ifdef LDCTRL_STALL_CNT_EN
      chk("rst_stall", 64'(stall_cycles), 0);
`endif
      @(posedge aclk); #1 aresetn = 1;
      in_load = 0;
      return;
    end
    chk("timeout", 64'(in_load), 0);
    for (int n = 0; n < 2; n++) begin
      @(posedge aclk); #1;
      drive(0, 0, 0, 0);
      @(negedge aclk); sample();
    end
    chk("ds_total", 64'(ds_cnt), 64'(b + k + i));
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("words%0d", e), 64'(rcv[e]), 64'(tgt[e]));
      chk($sformatf("starts%0d", e), 64'(st_cnt[e]), 64'(tgt[e] != 0));
    end
    chk("protocol", 64'(viol), 0);
    chk("load_done_cnt", 64'(ld_cnt), 1);
    chk("idle", 64'({busy, phase, load_done}), 0);
`ifdef LDCTRL_STALL_CNT_EN
    chk("stall", 64'(stall_cycles), 64'(stall_exp));
`endif
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    #1 chk("rst_outs", 64'({ds_read, bias_start, ker_start, if_start, bias_empty_n, ker_empty_n,
                            if_empty_n, busy, phase, load_done}), 0);
    aresetn = 1;
    run_load(4, 8, 16, 1, 0, 2, 0);
    run_load(0, 5, 0, 1, 0, 2, 0);
    run_load(0, 0, 0, 1, 0, 2, 0);
    run_load(3, 6, 2, 1, 1, 2, 0);
    run_load(2, 3, 2, 1, 0, 0, 0);
    run_load(4, 8, 16, 1, 0, 2, 1);
    run_load(1, 1, 1, 1, 0, 2, 0);
    repeat (6)
      run_load($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_phase_ctrl.md
# load_phase_ctrl

Sequences the DLA64 load phase: on a start pulse from the master FSM it streams the `get_ins` downstream word port to the bias, kernel and ifmap store engines in that order. For each phase it pulses the engine's start, forwards exactly the programmed number of words, and waits for the engine's done. When all three phases finish, it returns the end-of-load flag to the master FSM. It sits between `get_ins`, the three store engines and `fsm64`, and replaces ad-hoc `ds_read` wiring in the top level.

## Interface
- `CNT_W`, 16, width of word counts. Maximum words per phase is 2^CNT_W−1.
- `aclk` in 1: single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `load_start` in 1: one-cycle start pulse from the master FSM.
- `bias_words` / `ker_words` / `if_words` in CNT_W each: words per phase. 0 skips the phase. Sampled on `load_start`.
- `ds_empty_n` in 1: `get_ins` has a word available.
- `ds_read` out 1: pop one word from `get_ins`.
- `bias_start` / `ker_start` / `if_start` out 1 each: one-cycle engine start pulses.
- `bias_empty_n` / `ker_empty_n` / `if_empty_n` out 1 each: gated word-available signal, one per engine.
- `bias_read` / `ker_read` / `if_read` in 1 each: engine read requests.
- `bias_done` / `ker_done` / `if_done` in 1 each: engine finished pulses.
- `busy` out 1: high in every state other than IDLE.
- `phase` out 2: 0 = idle, 1 = bias, 2 = kernel, 3 = ifmap.
- `load_done` out 1: one-cycle pulse to the master FSM (`flag_fsld_end`).

## Operation
- States: IDLE, BIAS_RUN, BIAS_WAIT, KER_RUN, KER_WAIT, IF_RUN, IF_WAIT, DONE.
- IDLE + `load_start`:
  - Latch the three counts.
  - Go to the first RUN state whose count is nonzero. If all counts are 0, go to DONE.
- Entering a RUN state:
  - Pulse that phase's `*_start` for one cycle.
  - Load the remaining-word counter with the count.
  - Clear the sticky done flag.
- RUN, forwarding:
  - The active engine's `*_empty_n` equals `ds_empty_n`.
  - `ds_read` = active `*_read` & `ds_empty_n`.
  - Every cycle with `ds_read` = 1 decrements the counter.
- RUN, last word: `ds_read` with counter = 1 moves the FSM to the matching WAIT state.
- WAIT: the active `*_empty_n` is held at 0 and `ds_read` is held at 0.
- Done handling:
  - `*_done` sets the sticky done flag in either RUN or WAIT.
  - In WAIT with the flag set, advance to the next nonzero-count RUN state, or to DONE after the ifmap phase.
- DONE: assert `load_done` for one cycle, then return to IDLE.
- Inactive engines:
  - Their `*_empty_n` are always 0.
  - Their `*_read` and `*_done` inputs are ignored.
- `load_start` while `busy` is ignored.
- Reads from the active engine while `ds_empty_n` = 0 are not counted.

## Timing
- Reset, asynchronous with `aresetn` low:
  - State goes to IDLE; counters and latched counts clear to 0.
  - All outputs go to 0: `ds_read`, every `*_start`, every `*_empty_n`, `busy`, `phase`, `load_done`.
- Reset mid-phase aborts the phase. Words already popped are not restored.
- `load_start` sampled at edge N:
  - `busy`, `phase` and the first `*_start` are high in cycle N+1.
  - With all counts 0, `load_done` is high in cycle N+1.
- `*_start`, `load_done`, `busy` and `phase` are registered.
- `ds_read` and `*_empty_n` are combinational from state, `ds_empty_n` and `*_read`. There is zero-cycle latency through the controller.
- A `*_done` that arrives in the same cycle as the last `ds_read` is captured. The FSM enters WAIT with the flag set and advances one cycle later.
- Phase to phase: the next `*_start` comes one cycle after the WAIT cycle in which the flag is seen.
- The counter never wraps. `ds_read` is forced to 0 whenever the counter is 0.

## Configuration
- `LDCTRL_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` (32 bits).
  - It counts cycles in any RUN state where the active `*_read` = 1 and `ds_empty_n` = 0.
  - Cleared on `load_start`, held after DONE, saturates at all ones.
- `LDCTRL_STALL_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- `dla64_pkg` holds:
  - The state enum.
  - The phase encoding constants `PH_IDLE`, `PH_BIAS`, `PH_KER`, `PH_IF`.
  - The default `CNT_W`.
- One sub-module, `ld_word_cnt`: a loadable down-counter with decrement enable and a `one` flag (count = 1). It is instantiated once and reused across the phases.

## Test plan
- Counts 4/8/16 with `ds_empty_n` always high and engines reading continuously:
  - Exactly 28 `ds_read` pulses, in phase order bias → kernel → ifmap.
  - One start pulse per engine.
  - `load_done` 1 cycle after `if_done` is seen in IF_WAIT.
- Counts 0/5/0:
  - Only `ker_start` pulses and 5 words are forwarded.
  - Bias and ifmap engines see `*_empty_n` = 0 throughout.
- Counts 0/0/0: `load_start` → `load_done` high in the next cycle, with zero `ds_read`.
- Random `ds_empty_n` bubbles, `ker_read` held high past the count, counts 3/6/2:
  - `ds_read` total = 11, never asserted while `ds_empty_n` = 0.
  - With `LDCTRL_STALL_CNT_EN`, `stall_cycles` equals the number of bubble cycles.
- `bias_done` coinciding with the last bias read: KER_RUN is entered 2 cycles later. `load_start` pulsed mid-phase is ignored.
- `aresetn` dropped during KER_RUN: all outputs go to 0 immediately. A fresh `load_start` with counts 1/1/1 completes normally.
